// File: rtl/fir_pkg.sv
// Constants and helpers shared by the FIR, its output stage and the downstream formatter.
// The quantizer rounds half up, shifts arithmetically, then clamps to the sample range.
package fir_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = 32;
    localparam int SAT_MAX  = 32767;
    localparam int SAT_MIN  = -32768;

    typedef struct packed {
        logic                       sat;
        logic signed [SAMPLE_W-1:0] value;
    } quant_t;

    // The widened accumulator keeps the rounding offset from overflowing at the positive rail.
    function automatic quant_t quantize(input logic signed [ACC_W-1:0] x, input int shift);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] shr;
        logic signed [ACC_W:0] hi;
        logic signed [ACC_W:0] lo;
        quant_t                res;
        hi  = (ACC_W+1)'(SAT_MAX);
        lo  = (ACC_W+1)'(SAT_MIN);
        ext = {x[ACC_W-1], x};
        rnd = ext + ({{ACC_W{1'b0}}, 1'b1} << (shift - 1));
        shr = rnd >>> shift;
        if (shr > hi) begin
            res.sat   = 1'b1;
            res.value = SAMPLE_W'(SAT_MAX);
        end else if (shr < lo) begin
            res.sat   = 1'b1;
            res.value = SAMPLE_W'(SAT_MIN);
        end else begin
            res.sat   = 1'b0;
            res.value = shr[SAMPLE_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_out_decimator_if.sv
// Sample streams around the FIR output stage: raw filter results in, quantized samples out.
// master is the decimator side, slave is the filter/consumer side.
interface fir_out_decimator_if;
    import fir_pkg::*;

    logic signed [ACC_W-1:0]    in_data;
    logic                       in_valid;
    logic signed [SAMPLE_W-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_valid
    );

    modport slave (
        output in_data,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_valid
    );

endinterface

// File: rtl/fir_out_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible whenever not empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module fir_out_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Empty reads as zero so stale storage never leaks onto the output.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_decimator.sv
// FIR output stage: decimate, round/saturate to 16 bits, buffer in an FWFT FIFO,
// and report saturation, overflow and dropped-sample count.
module fir_out_decimator
    import fir_pkg::*;
#(
    parameter int DECIM = 4,
    parameter int SHIFT = 15,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fir_out_decimator_if.master  bus,
    input  logic                 clr_flags,
    output logic                 sat_sticky,
    output logic                 ovf_sticky,
    output logic [7:0]           drop_cnt
);

    localparam int               PH_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DECIM - 1);
    localparam int               CNT_W   = $clog2(DEPTH) + 1;

    logic [PH_W-1:0]            phase_reg;
    logic                       q_valid_reg;
    logic signed [SAMPLE_W-1:0] q_data_reg;
    logic                       keep;
    quant_t                     q_next;

    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CNT_W-1:0]           fifo_count;
    logic [SAMPLE_W-1:0]        fifo_head;
    logic                       drop;

    assign keep   = bus.in_valid && (phase_reg == '0);
    assign q_next = quantize(bus.in_data, SHIFT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_reg   <= '0;
            q_valid_reg <= 1'b0;
            q_data_reg  <= '0;
        end else begin
            if (bus.in_valid) begin
                phase_reg <= (phase_reg == PH_LAST) ? '0 : phase_reg + 1'b1;
            end
            q_valid_reg <= keep;
            if (keep) begin
                q_data_reg <= q_next.value;
            end
        end
    end

    // A pop on the same edge frees the slot, so a full FIFO still accepts the sample.
    assign fifo_pop  = !fifo_empty && bus.out_ready;
    assign fifo_push = q_valid_reg && ((fifo_count < CNT_W'(DEPTH)) || fifo_pop);
    assign drop      = q_valid_reg && fifo_full && !fifo_pop;

    fir_out_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (q_data_reg),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.out_data  = fifo_head;
    assign bus.out_valid = !fifo_empty;

    // A new event on the clearing edge takes priority over the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_sticky <= 1'b0;
            ovf_sticky <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (keep && q_next.sat) begin
                sat_sticky <= 1'b1;
            end else if (clr_flags) begin
                sat_sticky <= 1'b0;
            end
            if (drop) begin
                ovf_sticky <= 1'b1;
            end else if (clr_flags) begin
                ovf_sticky <= 1'b0;
            end
            if (drop) begin
                if (clr_flags) begin
                    drop_cnt <= 8'd1;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (clr_flags) begin
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench for fir_out_decimator with DECIM=4, SHIFT=15, DEPTH=4.
module tb_fir_out_decimator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_flags;
    logic       sat_sticky;
    logic       ovf_sticky;
    logic [7:0] drop_cnt;
    int         vectors = 0;
    int         miscompares = 0;

    fir_out_decimator_if bus ();

    fir_out_decimator #(
        .DECIM (4),
        .SHIFT (15),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .clr_flags  (clr_flags),
        .sat_sticky (sat_sticky),
        .ovf_sticky (ovf_sticky),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-14s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        clr_flags    = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Drives one kept sample plus three discarded ones; optionally checks the output after two edges.
    task automatic keep(input logic signed [31:0] v, input bit chk, input logic signed [31:0] exp, input string tag);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        tick();
        bus.in_data = 32'sd0;
        tick();
        if (chk) begin
            check({tag, "_v"}, 32'(bus.out_valid), 1);
            check({tag, "_d"}, $signed(bus.out_data), exp);
        end
        tick();
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bit pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int n;

        bus.out_ready = 1'b1;
        do_reset();
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_data", $signed(bus.out_data), 0);
        check("rst_sat", 32'(sat_sticky), 0);
        check("rst_ovf", 32'(ovf_sticky), 0);
        check("rst_drop", 32'(drop_cnt), 0);

        // Continuous stream: one output every 4 cycles, first two edges after accept.
        bus.in_data  = 32'sd32768;
        bus.in_valid = 1'b1;
        tick();
        check("dec_lat0", 32'(bus.out_valid), 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("dec_v%0d", i), 32'(bus.out_valid), (i % 4 == 1) ? 1 : 0);
            if (i % 4 == 1) check($sformatf("dec_d%0d", i), $signed(bus.out_data), 1);
        end
        bus.in_valid = 1'b0;

        do_reset();
        keep(-32'sd16384, 1'b1, 0, "rnd_m16384");
        keep(-32'sd16385, 1'b1, -1, "rnd_m16385");
        keep(32'sd16383, 1'b1, 0, "rnd_16383");
        keep(32'sd16384, 1'b1, 1, "rnd_16384");
        check("rnd_sat", 32'(sat_sticky), 0);

        keep(32'sh7FFF_FFFF, 1'b1, 32767, "sat_pos");
        check("sat_pos_flag", 32'(sat_sticky), 1);
        keep(32'sh8000_0000, 1'b1, -32768, "sat_neg");
        check("sat_neg_flag", 32'(sat_sticky), 1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("sat_clr", 32'(sat_sticky), 0);
        // Clear on the same edge as a new saturation: the set wins.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'sh7FFF_FFFF;
        clr_flags    = 1'b1;
        tick();
        clr_flags   = 1'b0;
        bus.in_data = 32'sd0;
        check("sat_clr_race", 32'(sat_sticky), 1);
        tick();
        tick();
        tick();
        bus.in_valid = 1'b0;

        // Backpressure: fifth sample overflows the four-entry FIFO.
        do_reset();
        bus.out_ready = 1'b0;
        for (int v = 1; v <= 4; v++) keep(32'(v) <<< 15, 1'b0, 0, "");
        check("bp_ovf_pre", 32'(ovf_sticky), 0);
        check("bp_drop_pre", 32'(drop_cnt), 0);
        keep(32'sd5 <<< 15, 1'b0, 0, "");
        check("bp_ovf", 32'(ovf_sticky), 1);
        check("bp_drop", 32'(drop_cnt), 1);
        check("bp_hold", $signed(bus.out_data), 1);
        bus.out_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            check($sformatf("drain_v%0d", v), 32'(bus.out_valid), 1);
            check($sformatf("drain_d%0d", v), $signed(bus.out_data), v);
            tick();
        end
        check("drain_empty", 32'(bus.out_valid), 0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("ovf_clr", 32'(ovf_sticky), 0);
        check("drop_clr", 32'(drop_cnt), 0);

        // Gapped in_valid: valid samples numbered n carry value n; #1 and #5 are kept.
        do_reset();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8 && pat[i]) begin
                n++;
                bus.in_valid = 1'b1;
                bus.in_data  = 32'(n) <<< 15;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            check($sformatf("gap_v%0d", i), 32'(bus.out_valid), (i == 1 || i == 8) ? 1 : 0);
            if (i == 1) check("gap_d1", $signed(bus.out_data), 1);
            if (i == 8) check("gap_d8", $signed(bus.out_data), 5);
        end
        bus.in_valid = 1'b0;

        // Reset with two queued entries and one sample in the quantizer.
        do_reset();
        bus.out_ready = 1'b0;
        keep(32'sd1 <<< 15, 1'b0, 0, "");
        keep(32'sd2 <<< 15, 1'b0, 0, "");
        bus.in_valid = 1'b1;
        bus.in_data  = 32'sd3 <<< 15;
        tick();
        check("mid_pre_v", 32'(bus.out_valid), 1);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("mid_rst_v", 32'(bus.out_valid), 0);
        check("mid_rst_d", $signed(bus.out_data), 0);
        check("mid_rst_drop", 32'(drop_cnt), 0);
        rst_n = 1'b1;
        tick();
        check("mid_stale", 32'(bus.out_valid), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'sd7 <<< 15;
        tick();
        bus.in_valid = 1'b0;
        check("mid_lat1", 32'(bus.out_valid), 0);
        tick();
        check("mid_new_v", 32'(bus.out_valid), 1);
        check("mid_new_d", $signed(bus.out_data), 7);
        bus.out_ready = 1'b1;
        tick();
        check("mid_popped", 32'(bus.out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
